// File: rtl/usbf_wb_mem_req.sv
// WISHBONE slave to SSRAM word requester; partial-byte writes become read-modify-write.
// Latency: read/full write ack 3 cycles after strobe drive, RMW 6 cycles, plus arbiter wait.
// Backpressure: holds wreq/wadr/wdout/wwe stable until wack; optional timeout via USBF_WB_TIMEOUT_EN.
module usbf_wb_mem_req #(
  parameter int SSRAM_HADR = 14,
  parameter int TMO_CYC    = 255
) (
  input  logic                  phy_clk,
  input  logic                  rst,
  input  logic [SSRAM_HADR+2:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [SSRAM_HADR:0]   wadr,
  output logic [31:0]           wdout,
  input  logic [31:0]           wdin,
  output logic                  wwe,
  output logic                  wreq,
  input  logic                  wack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SSRAM_HADR:0] r_wadr, w_wadr_nxt;
  logic [31:0]         r_wdout, w_wdout_nxt;
  logic                r_wwe, w_wwe_nxt;
  logic                r_wreq, w_wreq_nxt;
  logic [31:0]         r_dat_o, w_dat_o_nxt;
  logic                r_ack, w_ack_nxt;
  logic [3:0]          r_sel, w_sel_nxt;
  logic                r_gap, w_gap_nxt;
  logic                r_drop, w_drop_nxt;
  logic                w_done;
  logic                w_tmo;
  logic                w_clr_cnt;
  logic                w_unused;

  // wack only counts while our own request is outstanding
  assign w_done = r_wreq & wack;

`ifdef USBF_WB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // Abort on the edge where the waiting-cycle count would reach TMO_CYC
  assign w_tmo    = r_wreq & ~wack & (r_cnt == 8'(TMO_CYC - 1));
  assign wb_err_o = r_err;
  assign w_unused = ^wb_adr_i[1:0];

  // Waiting-cycle counter, restarted whenever a new memory request begins
  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (w_clr_cnt)
        r_cnt <= 8'd0;
      else if (r_wreq & ~wack)
        r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_tmo    = 1'b0;
  assign wb_err_o = 1'b0;
  assign w_unused = ^{wb_adr_i[1:0], w_clr_cnt, 8'(TMO_CYC)};
`endif

  // Next-state and next-output logic; every registered output is computed here
  always_comb begin
    w_state_nxt = r_state;
    w_wadr_nxt  = r_wadr;
    w_wdout_nxt = r_wdout;
    w_wwe_nxt   = r_wwe;
    w_wreq_nxt  = r_wreq;
    w_dat_o_nxt = r_dat_o;
    w_ack_nxt   = 1'b0;
    w_sel_nxt   = r_sel;
    w_gap_nxt   = r_gap;
    w_drop_nxt  = r_drop | ~wb_cyc_i;
    w_clr_cnt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_drop_nxt = 1'b0;
        w_gap_nxt  = 1'b0;
        if (wb_cyc_i & wb_stb_i) begin
          w_wadr_nxt  = wb_adr_i[SSRAM_HADR+2:2];
          // For RMW the write data parks in wdout until the merge overwrites it
          w_wdout_nxt = wb_dat_i;
          w_wreq_nxt  = 1'b1;
          w_clr_cnt   = 1'b1;
          if (!wb_we_i) begin
            w_wwe_nxt   = 1'b0;
            w_state_nxt = RD;
          end else if (wb_sel_i == 4'hF) begin
            w_wwe_nxt   = 1'b1;
            w_state_nxt = WR;
          end else begin
            w_wwe_nxt   = 1'b0;
            w_sel_nxt   = wb_sel_i;
            w_state_nxt = RMW_RD;
          end
        end
      end
      RD: begin
        if (w_done) begin
          w_dat_o_nxt = wdin;
          w_wreq_nxt  = 1'b0;
          w_ack_nxt   = ~w_drop_nxt;
          w_state_nxt = w_drop_nxt ? IDLE : ACK;
        end
      end
      RMW_RD: begin
        if (w_done) begin
          for (int n = 0; n < 4; n++)
            w_wdout_nxt[8*n +: 8] = r_sel[n] ? r_wdout[8*n +: 8] : wdin[8*n +: 8];
          // One idle cycle on wreq before the write request, handled in WR
          w_wreq_nxt  = 1'b0;
          w_gap_nxt   = 1'b1;
          w_clr_cnt   = 1'b1;
          w_state_nxt = WR;
        end
      end
      WR: begin
        if (r_gap) begin
          w_gap_nxt  = 1'b0;
          w_wreq_nxt = 1'b1;
          w_wwe_nxt  = 1'b1;
        end else if (w_done) begin
          w_wreq_nxt  = 1'b0;
          w_wwe_nxt   = 1'b0;
          w_ack_nxt   = ~w_drop_nxt;
          w_state_nxt = w_drop_nxt ? IDLE : ACK;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_tmo) begin
      w_wreq_nxt  = 1'b0;
      w_wwe_nxt   = 1'b0;
      w_gap_nxt   = 1'b0;
      w_ack_nxt   = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  // State and output registers
  always_ff @(posedge phy_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wadr  <= '0;
      r_wdout <= 32'd0;
      r_wwe   <= 1'b0;
      r_wreq  <= 1'b0;
      r_dat_o <= 32'd0;
      r_ack   <= 1'b0;
      r_sel   <= 4'd0;
      r_gap   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wadr  <= w_wadr_nxt;
      r_wdout <= w_wdout_nxt;
      r_wwe   <= w_wwe_nxt;
      r_wreq  <= w_wreq_nxt;
      r_dat_o <= w_dat_o_nxt;
      r_ack   <= w_ack_nxt;
      r_sel   <= w_sel_nxt;
      r_gap   <= w_gap_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign wb_dat_o = r_dat_o;
  assign wb_ack_o = r_ack;
  assign wadr     = r_wadr;
  assign wdout    = r_wdout;
  assign wwe      = r_wwe;
  assign wreq     = r_wreq;

endmodule

// File: tb/tb_usbf_wb_mem_req.sv
// Self-checking bench for usbf_wb_mem_req with a behavioural arbiter/memory and reference memory.
// Latency: expectations derived from arbiter wait per request (read/full 2+L, RMW 4+L1+L2).
// Backpressure: arbiter delays wack by a per-request latency; timeout case under USBF_WB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_usbf_wb_mem_req;

  localparam int HADR = 14;
  localparam int TMO  = 8;
`ifdef USBF_WB_TIMEOUT_EN
  localparam int MAX_LAT = 6;
`else
  localparam int MAX_LAT = 20;
`endif

  logic          phy_clk = 1'b0;
  logic          rst = 1'b0;
  logic [HADR+2:0] wb_adr_i = '0;
  logic [31:0]   wb_dat_i = 32'd0;
  logic [3:0]    wb_sel_i = 4'd0;
  logic          wb_we_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic [HADR:0] wadr;
  logic [31:0]   wdout;
  logic [31:0]   wdin = 32'd0;
  logic          wwe;
  logic          wreq;
  logic          wack = 1'b0;

  usbf_wb_mem_req #(.SSRAM_HADR(HADR), .TMO_CYC(TMO)) dut (
    .phy_clk(phy_clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wadr(wadr), .wdout(wdout), .wdin(wdin), .wwe(wwe), .wreq(wreq), .wack(wack)
  );

  always #5 phy_clk = ~phy_clk;

  int cyc_cnt = 0;
  always @(posedge phy_clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory seen by the DUT through the arbiter, and the reference view of it
  logic [31:0] mem     [0:32767];
  logic [31:0] ref_mem [0:32767];

  // Arbiter model state and per-transaction log
  int          arb_lat [2];
  int          req_n = 0;
  int          hcnt = 0;
  bit          acked = 1'b0;
  bit          spur = 1'b0;
  int          stab_err = 0;
  int          dup_err = 0;
  logic [HADR:0] h_adr;
  logic [31:0] h_dout;
  logic        h_we;
  int          q_rise[$];
  int          q_ack[$];
  logic        q_we[$];
  logic [HADR:0] q_adr[$];

  // Arbiter: answers each request after its configured number of waiting cycles
  always @(negedge phy_clk) begin
    wack = 1'b0;
    if (!rst) begin
      hcnt  = 0;
      acked = 1'b0;
    end else if (wreq) begin
      if (acked) begin
        dup_err++;
      end else begin
        hcnt++;
        if (hcnt == 1) begin
          q_rise.push_back(cyc_cnt);
          h_adr  = wadr;
          h_dout = wdout;
          h_we   = wwe;
        end else if (wadr !== h_adr || wdout !== h_dout || wwe !== h_we) begin
          stab_err++;
        end
        if (hcnt > ((req_n < 2) ? arb_lat[req_n] : 1)) begin
          wack = 1'b1;
          wdin = mem[wadr];
          if (wwe) mem[wadr] = wdout;
          q_ack.push_back(cyc_cnt);
          q_we.push_back(wwe);
          q_adr.push_back(wadr);
          acked = 1'b1;
          req_n++;
        end
      end
    end else begin
      hcnt  = 0;
      acked = 1'b0;
      if (spur) wack = 1'b1;
    end
  end

  task automatic arb_setup(input int l1, input int l2);
    arb_lat[0] = l1;
    arb_lat[1] = l2;
    req_n = 0;
    stab_err = 0;
    dup_err = 0;
    q_rise.delete();
    q_ack.delete();
    q_we.delete();
    q_adr.delete();
  endtask

  task automatic drive(input logic we, input logic [HADR+2:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
  endtask

  task automatic run_txn(input logic we, input logic [HADR+2:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int l1, input int l2, input string tag);
    int t0, acks, errs, ack_c;
    logic [HADR:0] wa;
    logic rmw;
    logic [31:0] old, expw, rdat;
    wa   = adr[HADR+2:2];
    rmw  = we && (sel != 4'hF);
    old  = ref_mem[wa];
    for (int n = 0; n < 4; n++)
      expw[8*n +: 8] = sel[n] ? dat[8*n +: 8] : old[8*n +: 8];
    arb_setup(l1, l2);
    @(posedge phy_clk); #1;
    drive(we, adr, dat, sel);
    t0 = cyc_cnt;
    acks = 0; errs = 0; ack_c = -1; rdat = 32'd0;
    for (int b = 0; b < 200 && acks == 0; b++) begin
      @(negedge phy_clk);
      if (wb_err_o) errs++;
      if (wb_ack_o) begin
        acks++;
        ack_c = cyc_cnt;
        rdat = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
      end
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    repeat (3) begin
      @(negedge phy_clk);
      if (wb_ack_o) acks++;
      if (wb_err_o) errs++;
    end
    check({tag, "_ack_cnt"}, 32'(acks), 32'd1);
    check({tag, "_err_cnt"}, 32'(errs), 32'd0);
    check({tag, "_latency"}, 32'(ack_c - t0), rmw ? 32'(4 + l1 + l2) : 32'(2 + l1));
    check({tag, "_nreq"}, 32'(q_ack.size()), rmw ? 32'd2 : 32'd1);
    check({tag, "_stable"}, 32'(stab_err), 32'd0);
    check({tag, "_dup"}, 32'(dup_err), 32'd0);
    if (q_ack.size() >= 1) begin
      check({tag, "_adr"}, 32'(q_adr[0]), 32'(wa));
      check({tag, "_we0"}, 32'(q_we[0]), 32'(we && !rmw));
    end
    if (rmw && q_ack.size() >= 2) begin
      check({tag, "_we1"}, 32'(q_we[1]), 32'd1);
      check({tag, "_adr1"}, 32'(q_adr[1]), 32'(wa));
      check({tag, "_gap"}, 32'(q_rise[1] - q_ack[0] - 1), 32'd1);
    end
    if (!we) begin
      check({tag, "_rdata"}, rdat, old);
    end else begin
      check({tag, "_mem"}, mem[wa], expw);
      ref_mem[wa] = expw;
    end
  endtask

  initial begin
    int acks, errs, hi, seen;
    logic we;
    logic [3:0] sel;
    logic [HADR+2:0] adr;
    logic [31:0] dat;

    for (int i = 0; i < 32768; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset values
    repeat (3) @(posedge phy_clk);
    #1;
    check("rst_wreq", 32'(wreq), 32'd0);
    check("rst_wwe", 32'(wwe), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_err", 32'(wb_err_o), 32'd0);
    check("rst_wadr", 32'(wadr), 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    rst = 1'b1;

    // Directed cases
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    run_txn(1'b0, 17'h0010, 32'h0, 4'hF, 1, 1, "rd");
    run_txn(1'b1, 17'h0020, 32'h12345678, 4'hF, 1, 1, "wr");
    mem[12] = 32'h11223344; ref_mem[12] = 32'h11223344;
    run_txn(1'b1, 17'h0030, 32'hAABBCCDD, 4'b0101, 1, 1, "rmw");
    check("rmw_word", mem[12], 32'h11BB33DD);
    run_txn(1'b1, 17'h0034, $urandom, 4'h0, 2, 3, "sel0");
    run_txn(1'b0, 17'h0044, 32'h0, 4'hF, MAX_LAT, 1, "cont_rd");
    run_txn(1'b1, 17'h0048, $urandom, 4'hF, MAX_LAT, 1, "cont_wr");
    run_txn(1'b1, 17'h004D, $urandom, 4'b1000, MAX_LAT, MAX_LAT, "cont_rmw");

    // Stray wack while idle must be ignored
    @(posedge phy_clk); #1;
    spur = 1'b1;
    @(posedge phy_clk); #1;
    spur = 1'b0;
    acks = 0; hi = 0;
    repeat (3) begin
      @(negedge phy_clk);
      if (wb_ack_o) acks++;
      if (wreq) hi++;
    end
    check("spur_ack", 32'(acks), 32'd0);
    check("spur_wreq", 32'(hi), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: sel = 4'hF;
        1: sel = 4'h0;
        default: sel = 4'($urandom);
      endcase
      adr = 17'($urandom_range(0, 1023));
      dat = $urandom;
      run_txn(we, adr, dat, sel, $urandom_range(1, MAX_LAT), $urandom_range(1, MAX_LAT),
              $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge phy_clk);
    end

    // Cycle dropped during a write: memory write completes, no ack
    arb_setup(6, 1);
    dat = 32'hCAFE0123;
    @(posedge phy_clk); #1;
    drive(1'b1, 17'h0100, dat, 4'hF);
    seen = 0;
    for (int b = 0; b < 20 && seen == 0; b++) begin
      @(negedge phy_clk);
      if (wreq) seen = 1;
    end
    check("abort_wreq_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge phy_clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    acks = 0;
    repeat (15) begin
      @(negedge phy_clk);
      if (wb_ack_o) acks++;
    end
    check("abort_ack", 32'(acks), 32'd0);
    check("abort_nreq", 32'(q_ack.size()), 32'd1);
    check("abort_mem", mem[64], dat);
    check("abort_wreq_idle", 32'(wreq), 32'd0);
    ref_mem[64] = dat;
    run_txn(1'b0, 17'h0100, 32'h0, 4'hF, 2, 1, "after_abort");

    // Asynchronous reset while waiting in RD
    arb_setup(1000, 1);
    @(posedge phy_clk); #1;
    drive(1'b0, 17'h0204, 32'h5A5A5A5A, 4'hF);
    seen = 0;
    for (int b = 0; b < 20 && seen == 0; b++) begin
      @(negedge phy_clk);
      if (wreq) seen = 1;
    end
    check("arst_wreq_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge phy_clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_wreq", 32'(wreq), 32'd0);
    check("arst_wwe", 32'(wwe), 32'd0);
    check("arst_wadr", 32'(wadr), 32'd0);
    check("arst_wdout", wdout, 32'd0);
    check("arst_dat_o", wb_dat_o, 32'd0);
    check("arst_ack", 32'(wb_ack_o), 32'd0);
    check("arst_err", 32'(wb_err_o), 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (2) @(posedge phy_clk);
    #1;
    rst = 1'b1;
    run_txn(1'b0, 17'h0204, 32'h0, 4'hF, 1, 1, "after_arst");

`ifdef USBF_WB_TIMEOUT_EN
    // No wack ever: request gives up after TMO waiting cycles with one error pulse
    arb_setup(1000, 1000);
    @(posedge phy_clk); #1;
    drive(1'b0, 17'h0300, 32'h0, 4'hF);
    acks = 0; errs = 0; hi = 0;
    repeat (30) begin
      @(negedge phy_clk);
      if (wreq) hi++;
      if (wb_ack_o) acks++;
      if (wb_err_o) begin
        errs++;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    check("tmo_wreq_cycles", 32'(hi), 32'(TMO));
    check("tmo_err", 32'(errs), 32'd1);
    check("tmo_ack", 32'(acks), 32'd0);
    run_txn(1'b0, 17'h0300, 32'h0, 4'hF, 1, 1, "after_tmo");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usbf_wb_mem_req.md
Name: usbf_wb_mem_req

Overview:
- WISHBONE-slave-to-memory-requester bridge. It drives the arbiter's WISHBONE-side memory port (wadr/wdout/wwe/wreq) and waits on wack.
- Converts classic single WISHBONE cycles from the host into SSRAM word accesses.
- Partial-byte writes are performed as a read-modify-write, because the SSRAM has only a 32-bit write enable.
- Sits between the host bus and the memory arbiter. The IDMA keeps priority, so wack may be delayed arbitrarily.

Parameters:
- SSRAM_HADR, 14, MSB index of the SSRAM word address.
- TMO_CYC, 255, timeout cycles (8-bit count). Used only with the optional feature.

Ports:
- phy_clk  in  1  clock. Same domain as the arbiter.
- rst  in  1  asynchronous, active-low reset.
- wb_adr_i  in  SSRAM_HADR+3  byte address. Bits [SSRAM_HADR+2:2] select the word.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lanes. Bit n selects bits [8n+7:8n].
- wb_we_i  in  1  write cycle.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error (timeout).
- wadr  out  SSRAM_HADR+1  word address to the arbiter.
- wdout  out  32  write data to the arbiter.
- wdin  in  32  read data from the arbiter, valid in the cycle wack=1.
- wwe  out  1  write qualifier.
- wreq  out  1  request.
- wack  in  1  acknowledge. Combinational from the arbiter; never high while mreq is active.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0.
- All outputs are registered.
- States: IDLE, RD, RMW_RD, WR, ACK.
- IDLE, when wb_cyc_i & wb_stb_i:
  - Latch wadr = wb_adr_i[SSRAM_HADR+2:2].
  - Read (!wb_we_i): go to RD with wreq=1, wwe=0.
  - Write with wb_sel_i=4'hF: go to WR with wdout=wb_dat_i, wwe=1, wreq=1.
  - Write with any other wb_sel_i, including 0: latch wb_dat_i and wb_sel_i, go to RMW_RD with wreq=1, wwe=0.
- RD: hold wreq until wack=1. On wack, wb_dat_o <= wdin, wreq <= 0, go to ACK.
- RMW_RD: on wack, form the merged word:
  - wdout lane n = wb_sel_i[n] ? wb_dat_i lane : wdin lane.
  - Keep wreq <= 0 for exactly one cycle, which the arbiter requires between requests.
  - Then re-assert wreq with wwe=1 and go to WR.
  - The merge is registered in the wack cycle; the re-request is issued from the following cycle.
- WR: hold wreq/wwe/wdout/wadr stable until wack. On wack, drop wreq and wwe, go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. A new strobe is not sampled in ACK.
- Minimum latency with no IDMA contention, strobe sampled at edge 0:
  - Read or full write: wreq at edge 1, wack in cycle 2, wb_ack_o cycle 3.
  - RMW: wb_ack_o at cycle 6.
- wreq deasserts in the cycle after wack, so the arbiter never produces a second wack for one access.
- While wreq=1, wadr/wdout/wwe never change.
- wack arriving while not in RD/RMW_RD/WR is ignored.
- If wb_cyc_i drops mid-access, the memory access still completes (no torn RMW). wb_ack_o is suppressed and the block returns to IDLE after wack.
- Asynchronous reset mid-access aborts immediately: wreq=0 next edge-free instant.

Optional Feature:
- Macro USBF_WB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to RD/RMW_RD/WR and increments each cycle wreq=1 & wack=0.
  - When the count reaches TMO_CYC: wreq <= 0, wwe <= 0, wb_err_o=1 for one cycle (no wb_ack_o), go to IDLE.
  - A timeout in RMW_RD does not perform the write.
- When undefined: no counter, wb_err_o tied 0, and the block waits for wack indefinitely.

Test Plan:
- Read, adr 0x0010, wack driven one cycle after wreq, wdin=0xDEADBEEF -> wadr=0x0004, wwe=0, wb_dat_o=0xDEADBEEF, wb_ack_o single pulse at cycle 3.
- Full write, adr 0x0020, dat 0x12345678, sel F -> wadr=0x0008, wdout=0x12345678, wwe=1 with wreq, one wack, one wb_ack_o.
- RMW write, sel 4'b0101, dat 0xAABBCCDD, memory word 0x11223344 -> read then write of 0x11BB33DD, wreq low exactly one cycle between the two requests.
- Contention: hold mreq so wack stays 0 for 20 cycles -> wreq and address stable throughout, single wb_ack_o after wack.
- Abort: wb_cyc_i dropped during WR -> write still completes on wack, no wb_ack_o, back to IDLE. Separately, rst low in RD -> all outputs 0.
- With USBF_WB_TIMEOUT_EN and TMO_CYC=8, wack never asserted -> wreq drops after 8 waiting cycles, wb_err_o pulses once, no wb_ack_o.
